// File: rtl/sound_player.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sound_player                                                    |
// | Plays ping/pong/go square-wave tones with a silent gap; SOUND_RETRIGGER_EN|
// | lets a new request preempt a running tone.                               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module sound_player #(
  parameter int HALF_PING = 6000,
  parameter int HALF_PONG = 12000,
  parameter int HALF_GO   = 3000,
  parameter int DUR       = 1200000,
  parameter int GAP       = 240000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] code_sound,
  input  logic       strobe,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0]  c_CODE_STOP = 2'b00;
  localparam logic [1:0]  c_CODE_PONG = 2'b01;
  localparam logic [1:0]  c_CODE_GO   = 2'b11;
  localparam logic [15:0] c_PING_LAST = 16'(HALF_PING - 1);
  localparam logic [15:0] c_PONG_LAST = 16'(HALF_PONG - 1);
  localparam logic [15:0] c_GO_LAST   = 16'(HALF_GO - 1);
  localparam logic [23:0] c_DUR_LAST  = 24'(DUR - 1);
  localparam logic [23:0] c_DUR_MID   = 24'(DUR / 2 - 1);
  localparam logic [23:0] c_GAP_LAST  = 24'(GAP - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_code, w_code_nxt;
  logic [15:0] r_tone_cnt, w_tone_nxt;
  logic [23:0] r_dur_cnt, w_dur_nxt;
  logic        r_phase, w_phase_nxt;
  logic        r_busy;
  logic        r_done, w_done_nxt;
  logic [15:0] w_half_last;
  logic        w_stop, w_start;

  assign w_stop  = strobe && (code_sound == c_CODE_STOP);
  assign w_start = strobe && (code_sound != c_CODE_STOP);

  // go switches to the ping pitch for the second half of its duration
  always_comb begin
    w_half_last = c_PING_LAST;
    if (r_code == c_CODE_PONG)
      w_half_last = c_PONG_LAST;
    else if (r_code == c_CODE_GO && r_dur_cnt <= c_DUR_MID)
      w_half_last = c_GO_LAST;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_tone_nxt  = r_tone_cnt;
    w_dur_nxt   = r_dur_cnt;
    w_phase_nxt = r_phase;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_code_nxt  = code_sound;
          w_tone_nxt  = '0;
          w_dur_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (r_tone_cnt == w_half_last) begin
          w_phase_nxt = ~r_phase;
          w_tone_nxt  = '0;
        end else begin
          w_tone_nxt  = r_tone_cnt + 16'd1;
        end
        if (r_code == c_CODE_GO && r_dur_cnt == c_DUR_MID)
          w_tone_nxt = '0;
        if (r_dur_cnt == c_DUR_LAST) begin
          w_state_nxt = ST_GAP;
          w_tone_nxt  = '0;
          w_dur_nxt   = '0;
          w_phase_nxt = 1'b0;
        end else begin
          w_dur_nxt   = r_dur_cnt + 24'd1;
        end
      end
      ST_GAP: begin
        w_phase_nxt = 1'b0;
        if (r_dur_cnt == c_GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_dur_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_dur_nxt   = r_dur_cnt + 24'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tone_nxt  = '0;
        w_dur_nxt   = '0;
        w_phase_nxt = 1'b0;
      end
    endcase

    // requests during a tone override any natural transition this cycle
    if (r_state != ST_IDLE) begin
      if (w_stop) begin
        w_state_nxt = ST_IDLE;
        w_tone_nxt  = '0;
        w_dur_nxt   = '0;
        w_phase_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
`ifdef SOUND_RETRIGGER_EN
      else if (w_start) begin
        w_state_nxt = ST_PLAY;
        w_code_nxt  = code_sound;
        w_tone_nxt  = '0;
        w_dur_nxt   = '0;
        w_phase_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_code     <= c_CODE_STOP;
      r_tone_cnt <= '0;
      r_dur_cnt  <= '0;
      r_phase    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_tone_cnt <= w_tone_nxt;
      r_dur_cnt  <= w_dur_nxt;
      r_phase    <= w_phase_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign speaker = r_phase & ~mute;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: doc/sound_player.md
SOUND_PLAYER -- requirements
Module: sound_player

Interface
REQ-001 SHALL have parameter HALF_PING, default 6000, meaning ping half-period in clk cycles (1 kHz at 12 MHz).
REQ-002 SHALL have parameter HALF_PONG, default 12000, meaning pong half-period in clk cycles (500 Hz).
REQ-003 SHALL have parameter HALF_GO, default 3000, meaning go half-period in clk cycles (2 kHz).
REQ-004 SHALL have parameter DUR, default 1200000, meaning tone length in clk cycles (100 ms).
REQ-005 SHALL have parameter GAP, default 240000, meaning silent gap after each tone in clk cycles.
REQ-006 SHALL have port clk  input  1  system clock; one clock, all state on its rising edge.
REQ-007 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port code_sound  input  2  sound code: 00 stop, 01 pong, 10 ping, 11 go.
REQ-009 SHALL have port strobe  input  1  single-cycle request qualifying code_sound.
REQ-010 SHALL have port mute  input  1  silence speaker, timing unaffected.
REQ-011 SHALL have port speaker  output  1  square-wave drive to buzzer.
REQ-012 SHALL have port busy  output  1  high in PLAY or GAP.
REQ-013 SHALL have port done  output  1  one-cycle pulse on GAP->IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY, GAP; busy = (state != IDLE), registered.
REQ-015 SHALL, in IDLE, on strobe=1 with code_sound != 00: latch code, clear tone counter, duration counter and phase, enter PLAY at that edge.
REQ-016 SHALL ignore strobe with code_sound = 00 in IDLE.
REQ-017 SHALL, in PLAY, increment a 16-bit tone counter each cycle; at count = half-1 toggle phase and clear counter.
REQ-018 SHALL select half-period from latched code: pong HALF_PONG, ping HALF_PING; go uses HALF_GO for the first DUR/2 cycles and HALF_PING for the rest (tone counter cleared at switch).
REQ-019 SHALL, in PLAY, increment a 24-bit duration counter; at count = DUR-1 enter GAP, clear phase and counters.
REQ-020 SHALL, in GAP, count GAP cycles with phase held 0, then enter IDLE and assert done for exactly one cycle.
REQ-021 SHALL drive speaker = phase AND NOT mute (combinational gate, zero-cycle mute response); phase starts 0, first rises HALF cycles after acceptance.
REQ-022 SHALL, on strobe=1 with code_sound = 00 in PLAY or GAP, abort to IDLE at that edge, phase 0, no done pulse.
REQ-023 SHALL give abort (REQ-022) priority over natural PLAY->GAP or GAP->IDLE transitions occurring in the same cycle.
REQ-024 SHALL require all parameters >= 2, halves < 2^16, DUR and GAP < 2^24.

Reset
REQ-025 SHALL, while clr=1, force state IDLE, phase 0, all counters 0, latched code 00, busy 0, done 0, independent of clk.
REQ-026 SHALL, on clr mid-tone, silence speaker immediately and never emit done for the aborted tone.
REQ-027 SHALL accept a strobe on the first clk edge after clr deasserts.

Configuration
REQ-028 SHALL, with SOUND_RETRIGGER_EN defined, accept strobe with code_sound != 00 in PLAY or GAP as a restart: latch new code, clear counters and phase, enter PLAY, no done for the preempted tone.
REQ-029 SHALL, without SOUND_RETRIGGER_EN, ignore strobe with code_sound != 00 in PLAY or GAP (stop-abort per REQ-022 still honoured).

Verification (HALF_PING=4, HALF_PONG=8, HALF_GO=2, DUR=64, GAP=16)
REQ-030 SHALL check: strobe with 10 in IDLE -> speaker toggles every 4 cycles, 8 rising edges, busy high 80 cycles, done pulse 1 cycle at cycle 80.
REQ-031 SHALL check: strobe with 11 -> period 4 cycles for cycles 0-31, period 8 cycles for cycles 32-63, then 16 silent cycles, done.
REQ-032 SHALL check: mute high cycles 10-30 during pong -> speaker 0 in that window, done still at cycle 80.
REQ-033 SHALL check: strobe with 00 at cycle 20 of ping -> busy 0 and speaker 0 next cycle, no done; coincident with PLAY end (cycle 63) -> same result.
REQ-034 SHALL check: clr pulse at cycle 30 of pong -> speaker 0 asynchronously, busy 0, no done; strobe first edge after release accepted.
REQ-035 SHALL check: strobe 01 at cycle 40 of ping -> with SOUND_RETRIGGER_EN new 80-cycle pong, one done total; without it, ping completes unchanged.
